// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin OBI arbiter: shares one OBI master port between NHARTS core data
// ports and routes each response back to the core that issued the request.

package ext_cpu_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

// Handshake rules: an address phase completes in the cycle where req and gnt
// are both high. Once req is raised it stays raised, with address-phase fields
// held stable, until gnt arrives; the arbiter enforces this by locking onto the
// presented winner. rvalid qualifies rdata for exactly one cycle, and responses
// return in issue order.
module ext_cpu_obi_arbiter
    import ext_cpu_obi_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2,
    localparam int IW = $clog2(NHARTS),
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  obi_req_t          core_data_req_i  [NHARTS],
    output obi_resp_t         core_data_resp_o [NHARTS],
    output obi_req_t          bus_req_o,
    input  obi_resp_t         bus_resp_i,
    output logic [CW-1:0]     outstanding_o,
    output logic              err_o,
    output logic              dbg_state_o,
    output logic [IW-1:0]     dbg_rr_ptr_o
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   lock_idx_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    logic [IW-1:0]   arb_idx;
    logic            arb_found;
    logic [IW-1:0]   winner;
    logic            winner_req;
    logic            can_issue;
    logic            handshake;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [IW-1:0]   head_idx;

    // Round-robin search: first requesting core at or after rr_ptr_q, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NHARTS; i++) begin
            cand = (int'(rr_ptr_q) + i) % NHARTS;
            if (!arb_found && core_data_req_i[cand].req) begin
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
    end

    // While locked the pending address phase keeps its owner; otherwise the
    // round-robin result wins.
    always_comb begin
        winner     = (state_q == LOCKED) ? lock_idx_q : arb_idx;
        winner_req = core_data_req_i[winner].req;
    end

    // The full check uses the registered count, so a slot freed by a pop this
    // cycle is only usable next cycle.
    assign can_issue  = (count_q != CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign handshake  = bus_req_o.req & bus_resp_i.gnt;
    assign push       = handshake;
    assign pop        = bus_resp_i.rvalid & ~fifo_empty;
    assign head_idx   = fifo_q[rd_ptr_q];

    // Forward the winner's address phase; every field is zero when nothing is presented.
    always_comb begin
        bus_req_o = '0;
        if (can_issue && winner_req) begin
            bus_req_o     = core_data_req_i[winner];
            bus_req_o.req = 1'b1;
        end
    end

    // Grant goes to the winner only; rvalid to the FIFO head; rdata is broadcast.
    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            core_data_resp_o[i].gnt    = handshake && (winner == IW'(i));
            core_data_resp_o[i].rvalid = pop && (head_idx == IW'(i));
            core_data_resp_o[i].rdata  = bus_resp_i.rdata;
        end
    end

    // Arbitration FSM and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (bus_req_o.req && !bus_resp_i.gnt) begin
                        state_q    <= LOCKED;
                        lock_idx_q <= winner;
                    end
                end
                LOCKED: begin
                    if (bus_resp_i.gnt) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
            if (handshake) begin
                rr_ptr_q <= (winner == IW'(NHARTS - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    // ID FIFO of granted winners; push and pop may happen together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Sticky error: a response arrived with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (bus_resp_i.rvalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
    assign dbg_state_o   = state_q;
    assign dbg_rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_ext_cpu_obi_arbiter.sv
// Directed bench for ext_cpu_obi_arbiter (NHARTS=3, MAX_OUTSTANDING=2).
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.

module tb_ext_cpu_obi_arbiter;
    import ext_cpu_obi_pkg::*;

    localparam int NHARTS = 3;
    localparam int MAXO   = 2;

    logic        clk;
    logic        rst_n;
    obi_req_t    core_req  [NHARTS];
    obi_resp_t   core_resp [NHARTS];
    obi_req_t    bus_req;
    obi_resp_t   bus_resp;
    logic [1:0]  outstanding;
    logic        err;
    logic        dbg_state;
    logic [1:0]  dbg_rr_ptr;

    int total;
    int bad;

    ext_cpu_obi_arbiter #(
        .NHARTS          (NHARTS),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .core_data_req_i  (core_req),
        .core_data_resp_o (core_resp),
        .bus_req_o        (bus_req),
        .bus_resp_i       (bus_resp),
        .outstanding_o    (outstanding),
        .err_o            (err),
        .dbg_state_o      (dbg_state),
        .dbg_rr_ptr_o     (dbg_rr_ptr)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gnt_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NHARTS; i++) v[i] = core_resp[i].gnt;
        return v;
    endfunction

    function automatic logic [31:0] rvalid_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NHARTS; i++) v[i] = core_resp[i].rvalid;
        return v;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < NHARTS; i++) core_req[i] = '0;
        bus_resp = '0;
    endtask

    task automatic set_req(input int idx, input logic r, input logic [31:0] addr);
        core_req[idx].req   = r;
        core_req[idx].we    = 1'b0;
        core_req[idx].be    = 4'hF;
        core_req[idx].addr  = addr;
        core_req[idx].wdata = addr ^ 32'h5A5A_0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();

        // Reset state
        @(negedge clk);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bus_req", 32'(bus_req.req), 0);
        check("rst_bus_addr", bus_req.addr, 0);
        check("rst_gnt", gnt_vec(), 0);
        check("rst_rvalid", rvalid_vec(), 0);
        check("rst_state", 32'(dbg_state), 0);
        tick();
        rst_n = 1'b1;

        // Single read from core1
        set_req(1, 1'b1, 32'h1000);
        bus_resp.gnt = 1'b1;
        @(negedge clk);
        check("t1_bus_req", 32'(bus_req.req), 1);
        check("t1_bus_addr", bus_req.addr, 32'h1000);
        check("t1_gnt", gnt_vec(), 32'b010);
        check("t1_out0", 32'(outstanding), 0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("t1_out1", 32'(outstanding), 1);
        check("t1_rr_ptr", 32'(dbg_rr_ptr), 2);
        check("t1_no_rvalid", rvalid_vec(), 0);
        check("t1_bus_idle", bus_req.addr, 0);
        tick();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_rvalid", rvalid_vec(), 32'b010);
        check("t1_rdata", core_resp[1].rdata, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        @(negedge clk);
        check("t1_out_end", 32'(outstanding), 0);
        check("t1_err", 32'(err), 0);

        // All three cores streaming, gnt always high, response one cycle after grant
        do_reset();
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < NHARTS; i++) set_req(i, k < 6, 32'h100 * (i + 1));
            bus_resp.gnt    = (k < 6);
            bus_resp.rvalid = (k >= 1);
            bus_resp.rdata  = 32'hA000 + k;
            @(negedge clk);
            if (k < 6) begin
                check($sformatf("t2_gnt_%0d", k), gnt_vec(), 32'(1) << (k % 3));
                check($sformatf("t2_addr_%0d", k), bus_req.addr, 32'h100 * ((k % 3) + 1));
            end
            if (k >= 1) begin
                check($sformatf("t2_rvalid_%0d", k), rvalid_vec(), 32'(1) << ((k - 1) % 3));
                check($sformatf("t2_rdata_%0d", k), core_resp[(k - 1) % 3].rdata, 32'hA000 + k);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        check("t2_out_end", 32'(outstanding), 0);

        // Address phase held while gnt is low
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_req(0, k < 4, 32'h3000);
            set_req(2, k >= 1, 32'h3300);
            bus_resp.gnt = (k >= 3);
            @(negedge clk);
            if (k < 3) begin
                check($sformatf("t3_addr_hold_%0d", k), bus_req.addr, 32'h3000);
                check($sformatf("t3_no_gnt_%0d", k), gnt_vec(), 0);
            end
            if (k == 1) check("t3_locked", 32'(dbg_state), 1);
            if (k == 3) begin
                check("t3_gnt_core0", gnt_vec(), 32'b001);
                check("t3_addr_core0", bus_req.addr, 32'h3000);
            end
            if (k == 4) begin
                check("t3_gnt_core2", gnt_vec(), 32'b100);
                check("t3_addr_core2", bus_req.addr, 32'h3300);
                check("t3_unlocked", 32'(dbg_state), 0);
            end
            tick();
        end

        // Outstanding limit
        do_reset();
        set_req(0, 1'b1, 32'h4000);
        bus_resp.gnt = 1'b1;
        tick();
        tick();
        set_req(0, 1'b0, 32'h0);
        set_req(1, 1'b1, 32'h4100);
        @(negedge clk);
        check("t4_full_req", 32'(bus_req.req), 0);
        check("t4_full_gnt", gnt_vec(), 0);
        check("t4_full_out", 32'(outstanding), 2);
        tick();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'h44;
        @(negedge clk);
        check("t4_pop_req", 32'(bus_req.req), 0);
        check("t4_pop_rvalid", rvalid_vec(), 32'b001);
        tick();
        bus_resp.rvalid = 1'b0;
        @(negedge clk);
        check("t4_issue_req", 32'(bus_req.req), 1);
        check("t4_issue_addr", bus_req.addr, 32'h4100);
        check("t4_issue_gnt", gnt_vec(), 32'b010);
        check("t4_issue_out", 32'(outstanding), 1);
        tick();

        // rvalid with nothing outstanding
        do_reset();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'h55;
        @(negedge clk);
        check("t5_no_rvalid", rvalid_vec(), 0);
        tick();
        bus_resp.rvalid = 1'b0;
        @(negedge clk);
        check("t5_err_set", 32'(err), 1);
        tick();
        tick();
        @(negedge clk);
        check("t5_err_sticky", 32'(err), 1);
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", 32'(err), 0);
        tick();

        // Reset with two transactions outstanding
        do_reset();
        set_req(0, 1'b1, 32'h6000);
        set_req(1, 1'b1, 32'h6100);
        bus_resp.gnt = 1'b1;
        tick();
        tick();
        clear_inputs();
        #1;
        check("t6_pre_out", 32'(outstanding), 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", 32'(outstanding), 0);
        check("t6_rst_rr", 32'(dbg_rr_ptr), 0);
        tick();
        rst_n = 1'b1;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'h66;
        @(negedge clk);
        check("t6_no_rvalid", rvalid_vec(), 0);
        tick();
        bus_resp.rvalid = 1'b0;
        @(negedge clk);
        check("t6_err", 32'(err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
